// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: fetch sequencer states, datapath widths and
// the branch opcode range that the branch unit and fetch unit agree on.
package kgp_risc_pkg;

  localparam int INSTR_WIDTH      = 32;
  localparam int PC_WIDTH_DEFAULT = 12;
  localparam int BR_TARGET_WIDTH  = 26;
  localparam int WAIT_CNT_WIDTH   = 3;

  // Branch opcodes occupy the contiguous range 48..59.
  localparam logic [5:0] OPC_B    = 6'd48;
  localparam logic [5:0] OPC_BL   = 6'd49;
  localparam logic [5:0] OPC_BCY  = 6'd50;
  localparam logic [5:0] OPC_BNCY = 6'd51;
  localparam logic [5:0] OPC_BLTZ = 6'd52;
  localparam logic [5:0] OPC_BZ   = 6'd53;
  localparam logic [5:0] OPC_BNZ  = 6'd54;
  localparam logic [5:0] OPC_BR   = 6'd55;
  localparam logic [5:0] OPC_BGEZ = 6'd56;
  localparam logic [5:0] OPC_BGTZ = 6'd57;
  localparam logic [5:0] OPC_BLEZ = 6'd58;
  localparam logic [5:0] OPC_BV   = 6'd59;

  typedef enum logic [2:0] {
    FETCH_RESET,
    FETCH_ISSUE,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_HALTED
  } fetch_state_e;

  function automatic logic is_branch_opcode(input logic [5:0] opc);
    return (opc >= OPC_B) && (opc <= OPC_BV);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: sequential pc+4 or the word-aligned branch target
// truncated to the instruction memory, plus the misaligned-target flag.
module pc_next_sel
  import kgp_risc_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0]        i_pc,
  input  logic                       i_is_branch,
  input  logic [BR_TARGET_WIDTH-1:0] i_branch_target,
  output logic [PC_WIDTH-1:0]        o_pc_plus4,
  output logic [PC_WIDTH-1:0]        o_pc_next,
  output logic                       o_misalign
);

  logic [PC_WIDTH-1:0] w_target;

  assign o_pc_plus4 = i_pc + PC_WIDTH'(4);
  assign w_target   = {i_branch_target[PC_WIDTH-1:2], 2'b00};
  assign o_pc_next  = i_is_branch ? w_target : o_pc_plus4;
  assign o_misalign = i_is_branch && (i_branch_target[1:0] != 2'b00);

  // Target bits beyond the PC width deliberately wrap into imem.
  generate
    if (PC_WIDTH < BR_TARGET_WIDTH) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^i_branch_target[BR_TARGET_WIDTH-1:PC_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch/PC sequencer: issues one imem read per instruction, holds
// the instruction until execute finishes, then steps or redirects the PC.
module instr_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int MEM_LATENCY = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_imem_en,
  output logic [PC_WIDTH-3:0]        o_imem_addr,
  input  logic [INSTR_WIDTH-1:0]     i_imem_rdata,
  output logic [INSTR_WIDTH-1:0]     o_instr,
  output logic                       o_instr_valid,
  output logic [PC_WIDTH-1:0]        o_pc,
  output logic [PC_WIDTH-1:0]        o_pc_plus4,
  input  logic                       i_exec_done,
  input  logic                       i_is_branch,
  input  logic [BR_TARGET_WIDTH-1:0] i_branch_target,
  input  logic                       i_halt_req,
  output logic                       o_halted,
  output logic                       o_misalign_err
);

  fetch_state_e               r_state;
  fetch_state_e               w_state_next;
  logic [PC_WIDTH-1:0]        r_pc;
  logic [PC_WIDTH-1:0]        w_pc_next;
  logic [PC_WIDTH-1:0]        w_pc_plus4;
  logic [INSTR_WIDTH-1:0]     r_instr;
  logic [WAIT_CNT_WIDTH-1:0]  r_wait_cnt;
  logic                       r_halt_latch;
  logic                       r_misalign;
  logic                       w_misalign;
  logic                       w_accept;
  logic                       w_wait_done;
  logic                       w_halt_pending;

  assign w_accept       = (r_state == FETCH_HOLD) && i_exec_done;
  assign w_wait_done    = (r_state == FETCH_WAIT) &&
                          (r_wait_cnt == WAIT_CNT_WIDTH'(MEM_LATENCY));
  assign w_halt_pending = i_halt_req || r_halt_latch;

  pc_next_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next_sel (
    .i_pc            (r_pc),
    .i_is_branch     (i_is_branch),
    .i_branch_target (i_branch_target),
    .o_pc_plus4      (w_pc_plus4),
    .o_pc_next       (w_pc_next),
    .o_misalign      (w_misalign)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_RESET:  w_state_next = FETCH_ISSUE;
      FETCH_ISSUE:  w_state_next = FETCH_WAIT;
      FETCH_WAIT:   if (w_wait_done) w_state_next = FETCH_HOLD;
      FETCH_HOLD:   if (i_exec_done)
                      w_state_next = w_halt_pending ? FETCH_HALTED : FETCH_ISSUE;
      FETCH_HALTED: w_state_next = FETCH_HALTED;
      default:      w_state_next = FETCH_RESET;
    endcase
  end

  // The PC only moves on an accepted exec_done, so it stays frozen in HALTED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= FETCH_RESET;
      r_pc         <= '0;
      r_instr      <= '0;
      r_wait_cnt   <= '0;
      r_halt_latch <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_misalign <= w_accept && w_misalign;
      if (i_halt_req && (r_state != FETCH_HALTED))
        r_halt_latch <= 1'b1;
      if (r_state == FETCH_ISSUE)
        r_wait_cnt <= WAIT_CNT_WIDTH'(1);
      else if ((r_state == FETCH_WAIT) && !w_wait_done)
        r_wait_cnt <= r_wait_cnt + WAIT_CNT_WIDTH'(1);
      if (w_wait_done)
        r_instr <= i_imem_rdata;
      if (w_accept)
        r_pc <= w_pc_next;
    end
  end

  assign o_imem_en      = (r_state == FETCH_ISSUE);
  assign o_imem_addr    = r_pc[PC_WIDTH-1:2];
  assign o_instr        = r_instr;
  assign o_instr_valid  = (r_state == FETCH_HOLD);
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_halted       = (r_state == FETCH_HALTED);
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a latency-1 and a latency-3
// instance, each fed by a behavioural imem, checked against a PC model.
module tb_instr_fetch_unit;

  localparam int WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_en, instr_valid, exec_done, is_branch, halt_req, halted, misalign_err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, instr;
  logic [11:0] pc, pc_plus4;
  logic [25:0] branch_target;

  logic        rst3, imem_en3, instr_valid3, exec_done3, is_branch3, halt_req3, halted3, misalign_err3;
  logic [9:0]  imem_addr3;
  logic [31:0] imem_rdata3, instr3;
  logic [11:0] pc3, pc_plus43;
  logic [25:0] branch_target3;

  logic [31:0] mem1 [WORDS];
  logic [31:0] mem3 [WORDS];

  int tests_run = 0;
  int tests_failed = 0;
  logic [11:0] exp_pc;

  instr_fetch_unit #(.PC_WIDTH(12), .MEM_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .o_imem_en(imem_en), .o_imem_addr(imem_addr),
    .i_imem_rdata(imem_rdata), .o_instr(instr), .o_instr_valid(instr_valid),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .i_exec_done(exec_done),
    .i_is_branch(is_branch), .i_branch_target(branch_target),
    .i_halt_req(halt_req), .o_halted(halted), .o_misalign_err(misalign_err)
  );

  instr_fetch_unit #(.PC_WIDTH(12), .MEM_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .o_imem_en(imem_en3), .o_imem_addr(imem_addr3),
    .i_imem_rdata(imem_rdata3), .o_instr(instr3), .o_instr_valid(instr_valid3),
    .o_pc(pc3), .o_pc_plus4(pc_plus43), .i_exec_done(exec_done3),
    .i_is_branch(is_branch3), .i_branch_target(branch_target3),
    .i_halt_req(halt_req3), .o_halted(halted3), .o_misalign_err(misalign_err3)
  );

  // Memories return the addressed word exactly LATENCY cycles after the
  // enable and random junk on every other cycle.
  logic [31:0] rd1 = '0, junk1 = '0;
  logic        v1 = 1'b0;
  always @(posedge clk) begin
    junk1 <= $urandom;
    v1    <= imem_en;
    if (imem_en) rd1 <= mem1[imem_addr];
  end
  assign imem_rdata = v1 ? rd1 : junk1;

  logic [31:0] d3 [3];
  logic [31:0] junk3 = '0;
  logic [2:0]  v3 = '0;
  always @(posedge clk) begin
    junk3 <= $urandom;
    v3    <= {v3[1:0], imem_en3};
    d3[2] <= d3[1];
    d3[1] <= d3[0];
    d3[0] <= mem3[imem_addr3];
  end
  assign imem_rdata3 = v3[2] ? d3[2] : junk3;

  function automatic logic [11:0] model_next(input logic [11:0] cur, input bit br,
                                             input logic [25:0] tgt);
    int unsigned p, t;
    p = cur;
    t = tgt;
    if (br) begin
      t = t % 4096;
      return 12'(t - (t % 4));
    end
    return 12'((p + 4) % 4096);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    is_branch     = 1'($urandom);
    branch_target = 26'($urandom);
  endtask

  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exec_done = 1'b0;
      noise();
      tick();
    end
    is_branch = 1'b0;
  endtask

  // exec_done is randomly pulsed while not yet valid; it must be ignored.
  task automatic wait_valid(output int n, output bit ok);
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      exec_done = 1'($urandom);
      noise();
      tick();
      n++;
    end
    exec_done = 1'b0;
    is_branch = 1'b0;
    ok = (instr_valid === 1'b1);
  endtask

  task automatic do_done(input bit br, input logic [25:0] tgt, input bit hreq);
    exec_done     = 1'b1;
    is_branch     = br;
    branch_target = tgt;
    halt_req      = hreq;
    tick();
    exec_done = 1'b0;
    is_branch = 1'b0;
    halt_req  = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({pc, instr_valid, imem_en, halted, misalign_err} !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got pc=%0h valid=%b en=%b halted=%b mis=%b expected all 0",
               pc, instr_valid, imem_en, halted, misalign_err);
    end
    tests_run++;
    if (instr !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_instr: got %08h expected 0", instr);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL release_issue: got en=%b addr=%0d expected en=1 addr=0", imem_en, imem_addr);
    end
    tick();
    tests_run++;
    if (imem_en !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait_state: got en=%b valid=%b expected 0 0", imem_en, instr_valid);
    end
    tick();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== mem1[0]) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch: got valid=%b instr=%08h expected 1 %08h", instr_valid, instr, mem1[0]);
    end
    exp_pc = 12'd0;
  endtask

  task automatic test_sequential();
    int n;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      hold_idle($urandom_range(0, 3));
      tests_run++;
      if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== mem1[exp_pc[11:2]]) begin
        tests_failed++;
        $display("[TB] FAIL seq_hold: got valid=%b pc=%0d instr=%08h expected 1 %0d %08h",
                 instr_valid, pc, instr, exp_pc, mem1[exp_pc[11:2]]);
      end
      tests_run++;
      if (pc_plus4 !== model_next(exp_pc, 1'b0, 26'd0)) begin
        tests_failed++;
        $display("[TB] FAIL seq_pc_plus4: got %0d expected %0d", pc_plus4, model_next(exp_pc, 1'b0, 26'd0));
      end
      do_done(1'b0, 26'd0, 1'b0);
      exp_pc = model_next(exp_pc, 1'b0, 26'd0);
      tests_run++;
      if (imem_en !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc[11:2]) begin
        tests_failed++;
        $display("[TB] FAIL seq_issue: got en=%b valid=%b addr=%0d expected 1 0 %0d",
                 imem_en, instr_valid, imem_addr, exp_pc[11:2]);
      end
      wait_valid(n, ok);
      tests_run++;
      if (!ok || n != 2) begin
        tests_failed++;
        $display("[TB] FAIL seq_latency: got %0d cycles (valid=%b) expected 2", n, ok);
      end
    end
  endtask

  task automatic test_branch();
    int n;
    bit ok, br, exp_mis;
    logic [25:0] tgt;
    restart();
    wait_valid(n, ok);
    exp_pc = 12'd0;
    do_done(1'b0, 26'd0, 1'b0);
    wait_valid(n, ok);
    do_done(1'b1, 26'd36, 1'b0);
    tests_run++;
    if (imem_addr !== 10'd9 || pc !== 12'd36 || misalign_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL branch36: got addr=%0d pc=%0d mis=%b expected 9 36 0", imem_addr, pc, misalign_err);
    end
    wait_valid(n, ok);
    tests_run++;
    if (!ok || instr !== mem1[9]) begin
      tests_failed++;
      $display("[TB] FAIL branch36_instr: got %08h expected %08h", instr, mem1[9]);
    end
    exp_pc = 12'd36;
    for (int k = 0; k < 10; k++) begin
      tgt = (k == 0) ? 26'h1003 : 26'($urandom);
      br  = (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      exp_mis = br && (tgt % 4 != 0);
      hold_idle($urandom_range(0, 2));
      do_done(br, tgt, 1'b0);
      exp_pc = model_next(exp_pc, br, tgt);
      tests_run++;
      if (misalign_err !== exp_mis || pc !== exp_pc || imem_addr !== exp_pc[11:2]) begin
        tests_failed++;
        $display("[TB] FAIL branch_rand: got mis=%b pc=%0h expected mis=%b pc=%0h (tgt=%0h br=%b)",
                 misalign_err, pc, exp_mis, exp_pc, tgt, br);
      end
      tick();
      tests_run++;
      if (misalign_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL misalign_pulse: got %b expected 0", misalign_err);
      end
      wait_valid(n, ok);
      tests_run++;
      if (!ok || pc !== exp_pc || instr !== mem1[exp_pc[11:2]]) begin
        tests_failed++;
        $display("[TB] FAIL branch_fetch: got pc=%0h instr=%08h expected %0h %08h",
                 pc, instr, exp_pc, mem1[exp_pc[11:2]]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    do_done(1'b1, 26'd4092, 1'b0);
    wait_valid(n, ok);
    tests_run++;
    if (!ok || pc !== 12'd4092 || pc_plus4 !== 12'd0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_top: got pc=%0d pc_plus4=%0d expected 4092 0", pc, pc_plus4);
    end
    do_done(1'b0, 26'd0, 1'b0);
    tests_run++;
    if (pc !== 12'd0 || imem_addr !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pc: got pc=%0d addr=%0d expected 0 0", pc, imem_addr);
    end
    wait_valid(n, ok);
    tests_run++;
    if (!ok || instr !== mem1[0]) begin
      tests_failed++;
      $display("[TB] FAIL wrap_instr: got %08h expected %08h", instr, mem1[0]);
    end
  endtask

  task automatic test_halt();
    int n;
    bit ok;
    restart();
    wait_valid(n, ok);
    do_done(1'b0, 26'd0, 1'b0);
    wait_valid(n, ok);
    do_done(1'b0, 26'd0, 1'b0);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_valid(n, ok);
    tests_run++;
    if (!ok || pc !== 12'd8 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL halt_pending: got pc=%0d halted=%b expected 8 0", pc, halted);
    end
    do_done(1'b0, 26'd0, 1'b0);
    tests_run++;
    if (halted !== 1'b1 || imem_en !== 1'b0 || instr_valid !== 1'b0 || pc !== 12'd12) begin
      tests_failed++;
      $display("[TB] FAIL halt_enter: got halted=%b en=%b valid=%b pc=%0d expected 1 0 0 12",
               halted, imem_en, instr_valid, pc);
    end
    for (int i = 0; i < 6; i++) begin
      exec_done = 1'($urandom);
      is_branch = 1'b1;
      branch_target = 26'($urandom);
      tick();
      tests_run++;
      if (halted !== 1'b1 || imem_en !== 1'b0 || instr_valid !== 1'b0 || pc !== 12'd12) begin
        tests_failed++;
        $display("[TB] FAIL halt_frozen: got halted=%b en=%b valid=%b pc=%0d expected 1 0 0 12",
                 halted, imem_en, instr_valid, pc);
      end
    end
    exec_done = 1'b0;
    is_branch = 1'b0;
    restart();
    wait_valid(n, ok);
    do_done(1'b1, 26'd40, 1'b1);
    tests_run++;
    if (pc !== 12'd40 || halted !== 1'b1 || imem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL halt_with_branch: got pc=%0d halted=%b en=%b expected 40 1 0", pc, halted, imem_en);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    restart();
    wait_valid(n, ok);
    do_done(1'b1, 26'd20, 1'b0);
    tests_run++;
    if (halted !== 1'b0 || imem_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latch_cleared: got halted=%b en=%b expected 0 1", halted, imem_en);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (pc !== 12'd0 || instr_valid !== 1'b0 || instr !== 32'd0 || imem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_in_wait: got pc=%0d valid=%b instr=%08h en=%b expected 0 0 0 0",
               pc, instr_valid, instr, imem_en);
    end
    tick();
    tests_run++;
    if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_restart: got en=%b addr=%0d expected 1 0", imem_en, imem_addr);
    end
    wait_valid(n, ok);
    tests_run++;
    if (!ok || instr !== mem1[0]) begin
      tests_failed++;
      $display("[TB] FAIL rst_wait_fetch: got %08h expected %08h", instr, mem1[0]);
    end
    do_done(1'b1, 26'd20, 1'b0);
    wait_valid(n, ok);
    tests_run++;
    if (!ok || pc !== 12'd20) begin
      tests_failed++;
      $display("[TB] FAIL hold_at_20: got pc=%0d expected 20", pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (pc !== 12'd0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_in_hold: got pc=%0d valid=%b expected 0 0", pc, instr_valid);
    end
    tick();
    tests_run++;
    if (imem_en !== 1'b1 || imem_addr !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_hold_restart: got en=%b addr=%0d expected 1 0", imem_en, imem_addr);
    end
  endtask

  task automatic test_latency();
    int n;
    bit br;
    logic [25:0] tgt;
    logic [11:0] exp3;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    tick();
    exp3 = 12'd0;
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (imem_en3 !== 1'b1 || imem_addr3 !== exp3[11:2]) begin
        tests_failed++;
        $display("[TB] FAIL lat3_issue: got en=%b addr=%0d expected 1 %0d", imem_en3, imem_addr3, exp3[11:2]);
      end
      n = 0;
      while (instr_valid3 !== 1'b1 && n < 20) begin
        exec_done3 = 1'($urandom);
        is_branch3 = 1'($urandom);
        branch_target3 = 26'($urandom);
        tick();
        n++;
      end
      exec_done3 = 1'b0;
      tests_run++;
      if (n != 4 || instr3 !== mem3[exp3[11:2]] || pc3 !== exp3) begin
        tests_failed++;
        $display("[TB] FAIL lat3_fetch: got %0d cycles instr=%08h pc=%0h expected 4 %08h %0h",
                 n, instr3, pc3, mem3[exp3[11:2]], exp3);
      end
      br  = 1'($urandom);
      tgt = 26'($urandom);
      exec_done3 = 1'b1;
      is_branch3 = br;
      branch_target3 = tgt;
      tick();
      exec_done3 = 1'b0;
      is_branch3 = 1'b0;
      exp3 = model_next(exp3, br, tgt);
      tests_run++;
      if (misalign_err3 !== (br && (tgt % 4 != 0)) || pc3 !== exp3) begin
        tests_failed++;
        $display("[TB] FAIL lat3_next: got mis=%b pc=%0h expected mis=%b pc=%0h",
                 misalign_err3, pc3, (br && (tgt % 4 != 0)), exp3);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem1[i] = $urandom;
      mem3[i] = $urandom;
    end
    rst = 1'b1;  exec_done = 1'b0;  is_branch = 1'b0;  branch_target = '0;  halt_req = 1'b0;
    rst3 = 1'b1; exec_done3 = 1'b0; is_branch3 = 1'b0; branch_target3 = '0; halt_req3 = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
